// File: rtl/uart_tx.sv
// Buffered UART transmitter: small FIFO feeding an 8N1 serialiser, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to add an even parity bit after data bit 7 (8E1 framing).
module uart_tx #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, boundary, empty, full, tx_n;
`ifdef UART_TX_PARITY_EN
  logic             parity;
`endif

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign ready    = !full;
  assign push     = data_valid && ready;
  assign boundary = (baud_cnt == LAST_CNT);
  assign busy     = (state != IDLE) || !empty;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (boundary) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (boundary && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_n = parity;
        if (boundary) state_n = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit so queued frames leave no gap.
        if (boundary) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tx    <= tx_n;

      if (state == IDLE || state_n != state || boundary) baud_cnt <= '0;
      else                                              baud_cnt <= baud_cnt + CNT_W'(1);

      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_idx <= '0;
        rd_ptr  <= rd_ptr + AW'(1);
`ifdef UART_TX_PARITY_EN
        parity  <= ^mem[rd_ptr];
`endif
      end else if (state == DATA && boundary) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 3'd1;
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frame vectors, burst/back-pressure, randomized loopback through a
// behavioural line decoder, and reset mid-frame.
module tb_uart_tx;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       ready, tx, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .ready(ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line decoder: samples each bit at its centre, counting from the first low sample.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  bit         in_frame = 1'b0;
  int         k, t0;
  logic [7:0] sh;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        k = 0;
        t0 = cyc;
      end
    end else begin
      k++;
      if (k == 5) chk("rx_start_mid", tx, 0);
      if (k >= 15 && k <= 85 && k % 10 == 5) sh[(k - 15) / 10] = tx;
`ifdef UART_TX_PARITY_EN
      if (k == 95) chk("rx_parity", tx, ^sh);
`endif
      if (k == FL - 5) begin
        chk("rx_stop", tx, 1);
        rx_q.push_back(sh);
        rx_t.push_back(t0);
        in_frame = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy || in_frame) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) chk("idle_timeout", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [10:0] line;   // line bits in time order, bit 0 = start bit
  } vec_t;
  vec_t vecs[5];

  initial begin
    int e0, g, bad_tx, bad_busy, n;
    int acc[6];
    logic [7:0] vals[256];
    logic [7:0] exp_q[$];
    logic [7:0] tmp;
    bit rdy, seen6;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'h07, 11'h60E};
    vecs[1] = '{8'h03, 11'h406};
    vecs[2] = '{8'h55, 11'h4AA};
    vecs[3] = '{8'hFF, 11'h5FE};
    vecs[4] = '{8'h01, 11'h602};
`else
    vecs[0] = '{8'h55, 11'h2AA};
    vecs[1] = '{8'h00, 11'h200};
    vecs[2] = '{8'hFF, 11'h3FE};
    vecs[3] = '{8'h01, 11'h202};
    vecs[4] = '{8'h80, 11'h300};
`endif

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", ready, 1);
      chk("idle_busy", busy, 0);
    end

    // Directed single frames
    foreach (vecs[v]) begin
      wait_idle();
      data_in = vecs[v].d;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      for (int m = 1; m <= FL + 1; m++) begin
        @(negedge clk);
        if (m == 1) chk("pre_start_tx", tx, 1);
        if (m >= 7 && (m - 7) % 10 == 0) chk("frame_bit", tx, vecs[v].line[(m - 7) / 10]);
        if (m == FL) chk("busy_in_stop", busy, 1);
        if (m == FL + 1) chk("busy_after_stop", busy, 0);
      end
    end

    // Burst of six with back-pressure
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    n = 0;
    g = 0;
    seen6 = 1'b0;
    while (n < 6 && g < 500) begin
      @(negedge clk);
      data_in = 8'h41 + 8'(n);
      data_valid = 1'b1;
      rdy = ready;
      if (n == 5 && !seen6) begin
        chk("burst_ready_low_6th", ready, 0);
        seen6 = 1'b1;
      end
      @(posedge clk);
      if (rdy) begin
        acc[n] = cyc + 1;
        n++;
      end
      g++;
    end
    @(negedge clk);
    data_valid = 1'b0;
    chk("burst_all_accepted", n, 6);
    for (int i = 1; i < 5; i++) chk("burst_accept_cycle", acc[i], acc[0] + i);
    chk("burst_6th_accept_cycle", acc[5], acc[0] + FL + 2);
    g = 0;
    while (rx_q.size() < 6 && g < 1200) begin
      @(negedge clk);
      g++;
    end
    chk("burst_frames", rx_q.size(), 6);
    for (int j = 0; j < rx_q.size() && j < 6; j++) begin
      chk("burst_data", rx_q[j], 8'h41 + 8'(j));
      chk("burst_start_time", rx_t[j], acc[0] + 2 + j * FL);
    end

    // Randomized loopback of all byte values
    wait_idle();
    rx_q.delete();
    rx_t.delete();
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      tmp = vals[i];
      vals[i] = vals[j];
      vals[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = ($urandom_range(0, 15) == 0) ? 150 : $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        data_valid = 1'b0;
      end
      @(negedge clk);
      data_in = vals[i];
      data_valid = 1'b1;
      g = 0;
      while (!ready && g < 1000) begin
        @(negedge clk);
        g++;
      end
      if (g >= 1000) chk("rand_ready_timeout", ready, 1);
      exp_q.push_back(vals[i]);
    end
    @(negedge clk);
    data_valid = 1'b0;
    g = 0;
    while (rx_q.size() < 256 && g < 40000) begin
      @(negedge clk);
      g++;
    end
    repeat (300) @(negedge clk);
    chk("rand_frame_count", rx_q.size(), 256);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) chk("rand_data", rx_q[i], exp_q[i]);

    // Reset during data bit 3 of 0xA5 with two bytes queued
    wait_idle();
    rx_q.delete();
    data_in = 8'hA5;
    data_valid = 1'b1;
    @(negedge clk);
    e0 = cyc;
    data_in = 8'h11;
    @(negedge clk);
    data_in = 8'h22;
    @(negedge clk);
    data_valid = 1'b0;
    while (cyc < e0 + 44) @(negedge clk);
    chk("mid_bit3_tx", tx, 0);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);
    rst = 1'b0;
    bad_tx = 0;
    bad_busy = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("post_rst_tx_low_cycles", bad_tx, 0);
    chk("post_rst_busy_cycles", bad_busy, 0);
    chk("post_rst_frames", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
